cfg_chain_ctrl: RTL and testbench

Word-parallel controller for a serial configuration chain of parametrised length. Firmware loads the chain image as 32-bit words over the user bus (or triggers from the logic analyzer). A shift engine then clocks the image out serially at a programmable rate, pulses a latch strobe, and captures the bits returning on the chain's tail for readback. It sits between the user-bus slave decode and the configurable fabric, replacing bit-per-access chain programming.

---
 rtl/cfg_chain_pkg.sv | 26 ++
 rtl/cfg_chain_shifter.sv | 78 +++++++
 rtl/cfg_chain_ctrl.sv | 136 +++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// rtl/cfg_chain_pkg.sv - shared constants, FSM state type and sizing helper for cfg_chain_ctrl
package cfg_chain_pkg;

   localparam logic [3:0] OFF_DATA     = 4'h0;
   localparam logic [3:0] OFF_CTRL     = 4'h4;
   localparam logic [3:0] OFF_STATUS   = 4'h8;
   localparam logic [3:0] OFF_READBACK = 4'hC;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_CLEAR_BIT = 1;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_e;

   function automatic int num_words(input int chain_len);
      return (chain_len + 31) / 32;
   endfunction

endpackage

// File: rtl/cfg_chain_shifter.sv
// rtl/cfg_chain_shifter.sv - shift FSM with CLK_DIV prescaler; bit index counts down from CHAIN_LEN-1
module cfg_chain_shifter
   import cfg_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 164,
   parameter int CLK_DIV   = 1,
   parameter int BW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   output logic [BW-1:0] bit_idx_o,
   output logic          sample_o,
   output logic          sen_o,
   output logic          slatch_o,
   output logic          busy_o
);

   localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
   localparam logic [7:0]    LAST_DIV = 8'(CLK_DIV - 1);

   state_e        state_q, state_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [7:0]    div_q, div_d;

   assign bit_idx_o = LAST_BIT - bit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      div_d    = div_q;
      sample_o = 1'b0;
      sen_o    = 1'b0;
      slatch_o = 1'b0;
      busy_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SHIFT;
               bit_d   = '0;
               div_d   = '0;
            end
         end
         SHIFT: begin
            sen_o  = 1'b1;
            busy_o = 1'b1;
            // last prescaler cycle of a bit period: sample tail, then advance
            if (div_q == LAST_DIV) begin
               sample_o = 1'b1;
               div_d    = '0;
               if (bit_q == LAST_BIT) state_d = LATCH;
               else                   bit_d   = bit_q + BW'(1);
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         LATCH: begin
            slatch_o = 1'b1;
            busy_o   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/cfg_chain_ctrl.sv
// rtl/cfg_chain_ctrl.sv - bus decode, image buffer and start arbitration for the config chain
// Readback capture buffer exists only when CFG_CHAIN_READBACK_EN is defined.
module cfg_chain_ctrl
   import cfg_chain_pkg::*;
#(
   parameter int          CHAIN_LEN = 164,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          CLK_DIV   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        wen,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic        la_start,
   output logic        sout,
   input  logic        sin,
   output logic        sen,
   output logic        slatch,
   output logic        busy
);

   localparam int NW = num_words(CHAIN_LEN);
   localparam int WW = (NW > 1) ? $clog2(NW) : 1;
   localparam int BW = WW + 5;
   localparam logic [WW-1:0] LAST_PTR = WW'(NW - 1);

   logic [31:0]   img_q [NW];
   logic [WW-1:0] wr_ptr_q, rd_ptr_q;
   logic          ready_q, done_q, err_q;
   logic [31:0]   rdata_q, rd_word, rb_word;
   logic          acc, data_wr, ctrl_wr, start_req, clear_req, start_go, rb_rd;
   logic          sample;
   logic [BW-1:0] bit_idx;

   // ready_q in the term enforces the idle cycle between acknowledges
   assign acc       = valid && !ready_q && (wb_addr[31:4] == BASE_ADDR[31:4]);
   assign data_wr   = acc && wen && (wb_addr[3:0] == OFF_DATA);
   assign ctrl_wr   = acc && wen && (wb_addr[3:0] == OFF_CTRL);
   assign start_req = (ctrl_wr && wdata[CTRL_START_BIT]) || la_start;
   assign clear_req = ctrl_wr && wdata[CTRL_CLEAR_BIT];
   assign start_go  = start_req && !busy;

   cfg_chain_shifter #(
      .CHAIN_LEN (CHAIN_LEN),
      .CLK_DIV   (CLK_DIV),
      .BW        (BW)
   ) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start_go),
      .bit_idx_o (bit_idx),
      .sample_o  (sample),
      .sen_o     (sen),
      .slatch_o  (slatch),
      .busy_o    (busy)
   );

   assign sout  = sen && img_q[bit_idx[BW-1:5]][bit_idx[4:0]];
   assign ready = ready_q;
   assign rdata = rdata_q;

`ifdef CFG_CHAIN_READBACK_EN
   logic [31:0] rb_q [NW];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NW; k++) rb_q[k] <= '0;
      end else if (sample) begin
         rb_q[bit_idx[BW-1:5]][bit_idx[4:0]] <= sin;
      end
   end

   assign rb_word = rb_q[rd_ptr_q];
   assign rb_rd   = acc && !wen && (wb_addr[3:0] == OFF_READBACK);
`else
   logic unused_rb;
   assign unused_rb = sin ^ sample;
   assign rb_word   = '0;
   assign rb_rd     = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (wb_addr[3:0])
         OFF_STATUS: begin
            rd_word[STAT_BUSY_BIT] = busy;
            rd_word[STAT_DONE_BIT] = done_q;
            rd_word[STAT_ERR_BIT]  = err_q;
            rd_word[15:8]          = 8'(wr_ptr_q);
            rd_word[23:16]         = 8'(rd_ptr_q);
         end
         OFF_READBACK: rd_word = rb_word;
         default:      rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NW; k++) img_q[k] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ready_q <= acc;
         rdata_q <= (acc && !wen) ? rd_word : '0;
         if (clear_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
         end
         if (data_wr) begin
            if (busy) begin
               err_q <= 1'b1;
            end else begin
               img_q[wr_ptr_q] <= wdata;
               wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + WW'(1);
            end
         end
         if (rb_rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + WW'(1);
         if (start_req) begin
            if (busy) err_q  <= 1'b1;
            else      done_q <= 1'b0;
         end
         if (slatch) done_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// tb/tb_cfg_chain_ctrl.sv - scoreboard bench: CLK_DIV=1 (loopback sin) and CLK_DIV=3 (sin delayed 2) instances
module tb_cfg_chain_ctrl;

   localparam int          CL   = 164;
   localparam int          NW   = 6;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic        wen = 1'b0;
   logic [31:0] wb_addr = '0;
   logic [31:0] wdata = '0;
   logic        la_start = 1'b0;
   logic [31:0] rdata1, rdata3;
   logic        ready1, ready3, sout1, sout3, sin1, sin3;
   logic        sen1, sen3, slatch1, slatch3, busy1, busy3;
   logic        d1q = 1'b0;
   logic        d2q = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] q1 [$];
   logic [32:0] q3 [$];
   logic [31:0] mw [NW];
   int          wp = 0;

   always #5 clk = ~clk;

   assign sin1 = sout1;
   always @(posedge clk) begin
      d1q <= sout3;
      d2q <= d1q;
   end
   assign sin3 = d2q;

   cfg_chain_ctrl #(.CHAIN_LEN(CL), .BASE_ADDR(BASE), .CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .valid(valid), .wen(wen), .wb_addr(wb_addr), .wdata(wdata),
      .rdata(rdata1), .ready(ready1), .la_start(la_start), .sout(sout1), .sin(sin1),
      .sen(sen1), .slatch(slatch1), .busy(busy1));

   cfg_chain_ctrl #(.CHAIN_LEN(CL), .BASE_ADDR(BASE), .CLK_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .valid(valid), .wen(wen), .wb_addr(wb_addr), .wdata(wdata),
      .rdata(rdata3), .ready(ready3), .la_start(la_start), .sout(sout3), .sin(sin3),
      .sen(sen3), .slatch(slatch3), .busy(busy3));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic sb_pop(input int sel);
      logic [32:0] e;
      logic [31:0] rd;
      if ((sel == 1 && q1.size() == 0) || (sel == 3 && q3.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected_ready dut%0d: got ready=1 want no pending access", sel);
      end else begin
         e  = (sel == 1) ? q1.pop_front() : q3.pop_front();
         rd = (sel == 1) ? rdata1 : rdata3;
         if (e[32]) chk($sformatf("sb_rdata_dut%0d", sel), rd, e[31:0]);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (ready1) sb_pop(1);
         if (ready3) sb_pop(3);
      end
   endtask

   task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                      input logic c, input logic [31:0] e1, input logic [31:0] e3);
      int n;
      q1.push_back({c, e1});
      q3.push_back({c, e3});
      valid   = 1'b1;
      wen     = w;
      wb_addr = BASE + {28'h0, off};
      wdata   = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready1 && n < 10);
      valid = 1'b0;
      wen   = 1'b0;
      if (!ready1) begin
         checks++;
         errors++;
         $display("FAIL bus_ack_timeout: got no ready within 10 cycles want ready");
         q1.delete();
         q3.delete();
      end
      @(posedge clk); #1;
      chk("ready_one_cycle", 32'(ready1), 32'd0);
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] e1, input logic [31:0] e3);
      bus(1'b0, off, 32'h0, 1'b1, e1, e3);
   endtask

   task automatic write_data(input logic [31:0] d);
      bus(1'b1, 4'h0, d, 1'b0, 32'h0, 32'h0);
      mw[3'(wp)] = d;
      wp = (wp + 1) % NW;
   endtask

   task automatic start_la();
      la_start = 1'b1;
      @(posedge clk); #1;
      la_start = 1'b0;
   endtask

   task automatic start_ctrl();
      q1.push_back({1'b0, 32'h0});
      q3.push_back({1'b0, 32'h0});
      valid   = 1'b1;
      wen     = 1'b1;
      wb_addr = BASE + 32'h4;
      wdata   = 32'h1;
      @(posedge clk); #1;
      valid = 1'b0;
      wen   = 1'b0;
   endtask

   function automatic logic [CL-1:0] image();
      logic [CL-1:0] v;
      for (int i = 0; i < CL; i++) v[8'(i)] = mw[3'(i / 32)][5'(i % 32)];
      return v;
   endfunction

   // called in cycle 1 after a start; follows one instance until busy drops
   task automatic watch(input int sel, input int div, input logic [CL-1:0] img, output logic first);
      int   c, sen_cnt, lat_cnt, lat_cyc, idle_cyc, bad;
      logic s_sen, s_sout, s_slatch, s_busy;
      c = 1; sen_cnt = 0; lat_cnt = 0; lat_cyc = -1; idle_cyc = -1; bad = 0; first = 1'b0;
      while (c < 2000) begin
         s_sen    = (sel == 3) ? sen3 : sen1;
         s_sout   = (sel == 3) ? sout3 : sout1;
         s_slatch = (sel == 3) ? slatch3 : slatch1;
         s_busy   = (sel == 3) ? busy3 : busy1;
         if (s_sen) begin
            if (sen_cnt == 0) first = s_sout;
            if (sen_cnt / div < CL && s_sout !== img[8'(CL - 1 - sen_cnt / div)]) bad++;
            sen_cnt++;
         end
         if (s_slatch) begin
            lat_cnt++;
            lat_cyc = c;
         end
         if (!s_busy) begin
            idle_cyc = c;
            break;
         end
         @(posedge clk); #1;
         c++;
      end
      chk($sformatf("sen_len_dut%0d", sel), 32'(sen_cnt), 32'(CL * div));
      chk($sformatf("slatch_count_dut%0d", sel), 32'(lat_cnt), 32'd1);
      chk($sformatf("slatch_cycle_dut%0d", sel), 32'(lat_cyc), 32'(CL * div + 1));
      chk($sformatf("idle_cycle_dut%0d", sel), 32'(idle_cyc), 32'(CL * div + 2));
      chk($sformatf("sout_stream_errs_dut%0d", sel), 32'(bad), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic f1, f3;
      int   n;
      logic [31:0] rb_a5, rb_w5, st_rd2;
      fork monitor(); join_none

`ifdef CFG_CHAIN_READBACK_EN
      rb_a5 = 32'hA5A5_A5A5; rb_w5 = 32'h0000_0005; st_rd2 = 32'h0002_0002;
`else
      rb_a5 = 32'h0;         rb_w5 = 32'h0;         st_rd2 = 32'h0000_0002;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({ready1, sen1, slatch1, busy1, sout1, ready3, sen3, slatch3, busy3, sout3}), 32'd0);
      chk("reset_rdata", rdata1 | rdata3, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      rd(4'h8, 32'h0, 32'h0);

      // image load, CTRL start, first bit is word5[3]
      write_data(32'h0123_4567); write_data(32'h89AB_CDEF); write_data(32'hF0F0_1234);
      write_data(32'h0000_FFFF); write_data(32'hDEAD_BEEF); write_data(32'hFFFF_FFF8);
      rd(4'h8, 32'h0, 32'h0);
      start_ctrl();
      fork
         watch(1, 1, image(), f1);
         watch(3, 3, image(), f3);
      join
      chk("first_sout_dut1", 32'(f1), 32'd1);
      chk("first_sout_dut3", 32'(f3), 32'd1);
      rd(4'h8, 32'h0000_0002, 32'h0000_0002);

      // loopback readback, two back-to-back runs
      for (int k = 0; k < NW; k++) write_data(32'hA5A5_A5A5);
      for (int r = 0; r < 2; r++) begin
         start_la();
         fork
            watch(1, 1, image(), f1);
            watch(3, 3, image(), f3);
         join
      end
      rd(4'hC, rb_a5, rb_a5);
      rd(4'hC, rb_a5, rb_a5);
      rd(4'h8, st_rd2, st_rd2);
      rd(4'hC, rb_a5, rb_a5);
      rd(4'hC, rb_a5, rb_a5);
      rd(4'hC, rb_a5, rb_a5);
      rd(4'hC, rb_w5, rb_w5);
      rd(4'h8, 32'h0000_0002, 32'h0000_0002);

      // CTRL start then la_start 10 cycles later
      write_data(32'h1234_5678);
      rd(4'h8, 32'h0000_0102, 32'h0000_0102);
      start_ctrl();
      fork
         watch(1, 1, image(), f1);
         watch(3, 3, image(), f3);
         begin
            repeat (9) begin @(posedge clk); #1; end
            la_start = 1'b1;
            @(posedge clk); #1;
            la_start = 1'b0;
            rd(4'h8, 32'h0000_0105, 32'h0000_0105);
         end
      join
      rd(4'h8, 32'h0000_0106, 32'h0000_0106);
      bus(1'b1, 4'h4, 32'h2, 1'b0, 32'h0, 32'h0);
      wp = 0;
      rd(4'h8, 32'h0, 32'h0);

      // DATA write while busy is discarded and flags err
      start_la();
      fork
         watch(1, 1, image(), f1);
         watch(3, 3, image(), f3);
         begin
            repeat (4) begin @(posedge clk); #1; end
            bus(1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
         end
      join
      rd(4'h8, 32'h0000_0006, 32'h0000_0006);
      bus(1'b1, 4'h4, 32'h2, 1'b0, 32'h0, 32'h0);

      // reset during bit 50 of dut1
      start_la();
      repeat (50) begin @(posedge clk); #1; end
      chk("pre_reset_busy", 32'({busy1, sen1, busy3, sen3}), 32'hF);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_mid_shift", 32'({sen1, busy1, slatch1, sout1, sen3, busy3, slatch3, sout3}), 32'd0);
      reset = 1'b0;
      n = 0;
      repeat (600) begin
         @(posedge clk); #1;
         if (slatch1 || slatch3 || busy1 || busy3) n++;
      end
      chk("no_activity_after_reset", 32'(n), 32'd0);
      rd(4'h8, 32'h0, 32'h0);

      // out-of-window read is never acknowledged
      valid   = 1'b1;
      wen     = 1'b0;
      wb_addr = BASE + 32'h20;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ready1 || ready3) n++;
      end
      valid = 1'b0;
      chk("oow_no_ready", 32'(n), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(q1.size() + q3.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
